tdm_mux8: RTL and testbench

TDM_MUX8 -- requirements
Module: tdm_mux8

---
 rtl/tdm_mux8_pkg.sv | 8 +
 rtl/tdm_mux8_rr_arb8.sv | 31 +++
 rtl/tdm_mux8.sv | 88 ++++++++
 tb/tb_tdm_mux8.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tdm_mux8_pkg.sv
// Shared constants for the 8-lane TDM collector and its round-robin arbiter.
package tdm_mux8_pkg;
   localparam int NUM_LANES = 8;
   localparam int SEL_W     = 3;
   localparam int CNT_W     = 16;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/tdm_mux8_rr_arb8.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins,
// searching upward and wrapping 7 -> 0.
module rr_arb8
   import tdm_mux8_pkg::*;
(
   input  logic [NUM_LANES-1:0] request_i,
   input  logic [SEL_W-1:0]     ptr_i,
   output logic [NUM_LANES-1:0] grant_o,
   output logic [SEL_W-1:0]     grant_idx_o
);

   logic             found;
   logic [SEL_W-1:0] idx;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         // Offset addition wraps naturally in SEL_W bits.
         idx = ptr_i + SEL_W'(k);
         if (!found && request_i[idx]) begin
            found          = 1'b1;
            grant_o[idx]   = 1'b1;
            grant_idx_o    = idx;
         end
      end
   end

endmodule

// File: rtl/tdm_mux8.sv
// 8-lane time-division collector: round-robin picks one eligible lane per
// cycle into a single registered output stage with a saturating beat counter.
module tdm_mux8
   import tdm_mux8_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_LANES-1:0]       lane_en,
   input  logic [NUM_LANES-1:0]       in_valid,
   input  logic [NUM_LANES*WIDTH-1:0] in_data,
   output logic [NUM_LANES-1:0]       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [SEL_W-1:0]           out_sel,
   output logic [CNT_W-1:0]           beat_cnt
);

   logic [NUM_LANES-1:0][WIDTH-1:0] lanes;
   logic [NUM_LANES-1:0]            eligible;
   logic [NUM_LANES-1:0]            grant;
   logic [SEL_W-1:0]                grant_idx;
   logic                            load_en;
   logic                            accept;

   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     out_data_q,  out_data_d;
   logic [SEL_W-1:0]     out_sel_q,   out_sel_d;
   logic [SEL_W-1:0]     ptr_q,       ptr_d;
   logic [CNT_W-1:0]     cnt_q,       cnt_d;

   assign lanes    = in_data;
   assign eligible = in_valid & lane_en;
   assign load_en  = !out_valid_q || out_ready;

   rr_arb8 u_arb (
      .request_i   (eligible),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   assign accept   = load_en && (|grant);
   // Reset forces ready low combinationally so no beat is taken while held.
   assign in_ready = (rst_n && load_en) ? grant : '0;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = lanes[grant_idx];
         out_sel_d   = grant_idx;
         ptr_d       = grant_idx + SEL_W'(1);
      end else if (load_en) begin
         out_valid_d = 1'b0;
      end
      if (out_valid_q && out_ready && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_tdm_mux8.sv
// Directed bench for tdm_mux8: reset, single lane, fairness, stall, lane
// masking, asynchronous reset and counter saturation.
module tb_tdm_mux8;

   localparam int W = 8;

   logic          clk;
   logic          rst_n;
   logic [7:0]    lane_en;
   logic [7:0]    in_valid;
   logic [8*W-1:0] in_data;
   logic [7:0]    in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [2:0]    out_sel;
   logic [15:0]   beat_cnt;

   int errors = 0;
   int checks = 0;

   tdm_mux8 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lane_en   (lane_en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .beat_cnt  (beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_seq [8];
      exp_seq = '{0, 1, 2, 4, 5, 6, 7, 0};

      rst_n     = 1'b0;
      lane_en   = 8'hFF;
      in_valid  = 8'hFF;
      in_data   = {8{8'hA5}};
      out_ready = 1'b1;
      #3;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data",  {24'd0, out_data}, 32'd0);
      chk("rst_out_sel",   {29'd0, out_sel}, 32'd0);
      chk("rst_beat_cnt",  {16'd0, beat_cnt}, 32'd0);
      chk("rst_in_ready",  {24'd0, in_ready}, 32'd0);

      // Single lane 3 beat
      in_valid = 8'h08;
      in_data  = '0;
      in_data[3*W +: W] = 8'hA5;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("l3_in_ready", {24'd0, in_ready}, 32'h08);
      step();
      chk("l3_out_valid", {31'd0, out_valid}, 32'd1);
      chk("l3_out_data",  {24'd0, out_data}, 32'hA5);
      chk("l3_out_sel",   {29'd0, out_sel}, 32'd3);
      in_valid = 8'h00;
      #1;
      chk("idle_in_ready", {24'd0, in_ready}, 32'd0);
      step();
      chk("l3_beat_cnt",   {16'd0, beat_cnt}, 32'd1);
      chk("drain_valid",   {31'd0, out_valid}, 32'd0);
      chk("drain_hold_data", {24'd0, out_data}, 32'hA5);
      chk("drain_hold_sel",  {29'd0, out_sel}, 32'd3);

      // Fairness from reset: 0..7,0..7
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) in_data[i*W +: W] = 8'(i);
      in_valid = 8'hFF;
      for (int k = 0; k < 16; k++) begin
         step();
         chk($sformatf("rr_sel_%0d", k),   {29'd0, out_sel}, 32'(k % 8));
         chk($sformatf("rr_data_%0d", k),  {24'd0, out_data}, 32'(k % 8));
         chk($sformatf("rr_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      end
      in_valid = 8'h00;
      step();
      chk("rr_beat_cnt", {16'd0, beat_cnt}, 32'd16);
      chk("rr_drained",  {31'd0, out_valid}, 32'd0);

      // Stall with lanes 2 and 5
      in_valid  = 8'h24;
      out_ready = 1'b0;
      step();
      chk("stall_first_sel", {29'd0, out_sel}, 32'd2);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("stall_in_ready_%0d", k), {24'd0, in_ready}, 32'd0);
         step();
         chk($sformatf("stall_sel_%0d", k),   {29'd0, out_sel}, 32'd2);
         chk($sformatf("stall_data_%0d", k),  {24'd0, out_data}, 32'd2);
         chk($sformatf("stall_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("unstall_in_ready", {24'd0, in_ready}, 32'h20);
      step();
      chk("unstall_sel", {29'd0, out_sel}, 32'd5);
      in_valid = 8'h00;
      step();
      chk("stall_beat_cnt", {16'd0, beat_cnt}, 32'd18);

      // Asynchronous reset with a beat in the output stage
      in_valid = 8'hFF;
      step();
      chk("pre_rst_sel",   {29'd0, out_sel}, 32'd6);
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid",    {31'd0, out_valid}, 32'd0);
      chk("async_beat_cnt", {16'd0, beat_cnt}, 32'd0);
      chk("async_in_ready", {24'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      lane_en = 8'hF7;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("mask_ready3_%0d", k), {31'd0, in_ready[3]}, 32'd0);
         step();
         chk($sformatf("mask_sel_%0d", k), {29'd0, out_sel}, 32'(exp_seq[k]));
      end

      // Counter saturation
      rst_n = 1'b0;
      #1;
      rst_n   = 1'b1;
      lane_en = 8'hFF;
      in_valid = 8'hFF;
      out_ready = 1'b1;
      for (int k = 0; k < 65535; k++) @(posedge clk);
      #1;
      chk("sat_fffe", {16'd0, beat_cnt}, 32'hFFFE);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("sat_ffff_%0d", k), {16'd0, beat_cnt}, 32'hFFFF);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
